btn_cond: RTL and testbench

BTN_COND -- requirements
Module: btn_cond

---
 rtl/btn_cond.sv | 183 ++++++++++++++++++
 tb/tb_btn_cond.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/btn_cond.sv
// btn_cond: conditions the two raw frequency buttons into one-cycle strobes.
// Each button goes through a two-flop synchronizer and a debounce counter,
// then through a small IDLE/DELAY/REPEAT machine that generates auto-repeat.
// The strobes are registered. They are masked while both buttons are down.
module btn_cond #(
  parameter int DB_CYCLES = 1000000,
  parameter int REP_DELAY = 50000000,
  parameter int REP_RATE  = 20000000
) (
  input  logic CLKNEXYS,
  input  logic reset,
  input  logic btn_up_i,
  input  logic btn_dn_i,
  output logic aumf_o,
  output logic bajaf_o,
  output logic up_lvl_o,
  output logic dn_lvl_o
);

  localparam int REP_MAX = (REP_DELAY > REP_RATE) ? REP_DELAY : REP_RATE;
  localparam int DW      = $clog2(DB_CYCLES + 1);
  localparam int RW      = $clog2(REP_MAX + 1);

  // The terminal values are held as count-1 so that a counter never needs a
  // wider adder output than its own width.
  localparam logic [DW-1:0] DB_LAST    = DW'(DB_CYCLES - 1);
  localparam logic [RW-1:0] DELAY_LAST = RW'(REP_DELAY - 1);
  localparam logic [RW-1:0] RATE_LAST  = RW'(REP_RATE - 1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_DELAY  = 2'd1;
  localparam logic [1:0] S_REPEAT = 2'd2;

  // Index 0 is the up button and index 1 is the down button.
  logic [1:0] btn_raw;
  logic [1:0] lvl;
  logic [1:0] evt;

  assign btn_raw = {btn_dn_i, btn_up_i};

  for (genvar gi = 0; gi < 2; gi++) begin : g_btn
    logic          sync1_q;
    logic          sync2_q;
    logic [DW-1:0] db_cnt_q;
    logic [DW-1:0] db_cnt_d;
    logic          lvl_q;
    logic          lvl_d;
    logic [1:0]    state_q;
    logic [1:0]    state_d;
    logic [RW-1:0] rep_cnt_q;
    logic [RW-1:0] rep_cnt_d;
    logic          evt_d;

    // Bring the asynchronous raw button into the clock domain.
    always_ff @(posedge CLKNEXYS or negedge reset) begin
      if (!reset) begin
        sync1_q <= 1'b0;
        sync2_q <= 1'b0;
      end else begin
        sync1_q <= btn_raw[gi];
        sync2_q <= sync1_q;
      end
    end

    // The level flips only after DB_CYCLES consecutive disagreeing samples.
    // Any agreeing sample restarts the count, so shorter glitches are ignored.
    always_comb begin
      db_cnt_d = '0;
      lvl_d    = lvl_q;
      if (sync2_q != lvl_q) begin
        if (db_cnt_q == DB_LAST) begin
          lvl_d    = ~lvl_q;
          db_cnt_d = '0;
        end else begin
          db_cnt_d = db_cnt_q + 1'b1;
        end
      end
    end

    // Debounce state registers.
    always_ff @(posedge CLKNEXYS or negedge reset) begin
      if (!reset) begin
        db_cnt_q <= '0;
        lvl_q    <= 1'b0;
      end else begin
        db_cnt_q <= db_cnt_d;
        lvl_q    <= lvl_d;
      end
    end

    // Auto-repeat machine. A released button takes priority over a terminal
    // count, so no pulse is issued in the cycle that the level has dropped.
    always_comb begin
      state_d   = state_q;
      rep_cnt_d = rep_cnt_q;
      evt_d     = 1'b0;
      case (state_q)
        S_IDLE: begin
          rep_cnt_d = '0;
          if (lvl_q) begin
            state_d = S_DELAY;
            evt_d   = 1'b1;
          end
        end
        S_DELAY: begin
          if (!lvl_q) begin
            state_d   = S_IDLE;
            rep_cnt_d = '0;
          end else if (rep_cnt_q == DELAY_LAST) begin
            state_d   = S_REPEAT;
            rep_cnt_d = '0;
            evt_d     = 1'b1;
          end else begin
            rep_cnt_d = rep_cnt_q + 1'b1;
          end
        end
        S_REPEAT: begin
          if (!lvl_q) begin
            state_d   = S_IDLE;
            rep_cnt_d = '0;
          end else if (rep_cnt_q == RATE_LAST) begin
            rep_cnt_d = '0;
            evt_d     = 1'b1;
          end else begin
            rep_cnt_d = rep_cnt_q + 1'b1;
          end
        end
        default: begin
          state_d   = S_IDLE;
          rep_cnt_d = '0;
        end
      endcase
    end

    // Auto-repeat state registers.
    always_ff @(posedge CLKNEXYS or negedge reset) begin
      if (!reset) begin
        state_q   <= S_IDLE;
        rep_cnt_q <= '0;
      end else begin
        state_q   <= state_d;
        rep_cnt_q <= rep_cnt_d;
      end
    end

    assign lvl[gi] = lvl_q;
    assign evt[gi] = evt_d;
  end

  // Pressing both buttons means the request is ambiguous, so both strobes
  // are dropped. An event can only occur while its own level is high, so
  // this mask also keeps the two strobes from firing in the same cycle.
  logic both_hi;
  logic aumf_q;
  logic aumf_d;
  logic bajaf_q;
  logic bajaf_d;

  assign both_hi = lvl[0] & lvl[1];

  // Gate the raw events with the ambiguity mask.
  always_comb begin
    aumf_d  = evt[0] & ~both_hi;
    bajaf_d = evt[1] & ~both_hi;
  end

  // Register the strobes. Reset clears them at once, without a clock edge.
  always_ff @(posedge CLKNEXYS or negedge reset) begin
    if (!reset) begin
      aumf_q  <= 1'b0;
      bajaf_q <= 1'b0;
    end else begin
      aumf_q  <= aumf_d;
      bajaf_q <= bajaf_d;
    end
  end

  assign aumf_o   = aumf_q;
  assign bajaf_o  = bajaf_q;
  assign up_lvl_o = lvl[0];
  assign dn_lvl_o = lvl[1];

endmodule

// File: tb/tb_btn_cond.sv
// Directed bench for btn_cond with short debounce and repeat periods.
// "Edge 0" is the clock edge after which a button is driven.
// "Edge k" is the k-th rising edge after edge 0.
module tb_btn_cond;

  logic clk;
  logic rst_n;
  logic btn_up;
  logic btn_dn;
  logic aumf;
  logic bajaf;
  logic up_lvl;
  logic dn_lvl;

  int vec_cnt;
  int miscmp_cnt;

  btn_cond #(
    .DB_CYCLES(4),
    .REP_DELAY(10),
    .REP_RATE (3)
  ) dut (
    .CLKNEXYS(clk),
    .reset   (rst_n),
    .btn_up_i(btn_up),
    .btn_dn_i(btn_dn),
    .aumf_o  (aumf),
    .bajaf_o (bajaf),
    .up_lvl_o(up_lvl),
    .dn_lvl_o(dn_lvl)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      miscmp_cnt++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end else begin
      $display("ok   %s: %0d", tag, got);
    end
  endtask

  initial begin
    int pulses;
    int bounce_len [10];
    logic bval;
    bounce_len = '{1, 3, 2, 1, 3, 2, 3, 1, 2, 2};
    vec_cnt    = 0;
    miscmp_cnt = 0;
    rst_n  = 1'b0;
    btn_up = 1'b0;
    btn_dn = 1'b0;

    // Reset state
    repeat (3) tick();
    chk("rst_aumf",   aumf,   0);
    chk("rst_bajaf",  bajaf,  0);
    chk("rst_up_lvl", up_lvl, 0);
    chk("rst_dn_lvl", dn_lvl, 0);
    rst_n = 1'b1;

    // Clean press followed by auto-repeat. The button is released after edge 33.
    // The level then falls at edge 39, which leaves nine up pulses:
    // 7, 17, 20, 23, 26, 29, 32, 35 and 38.
    tick();
    btn_up = 1'b1;
    pulses = 0;
    for (int k = 1; k <= 60; k++) begin
      tick();
      chk($sformatf("rep_aumf@%0d", k), aumf,
          (k == 7 || (k >= 17 && k <= 38 && (k - 17) % 3 == 0)) ? 1 : 0);
      chk($sformatf("rep_bajaf@%0d", k), bajaf, 0);
      chk($sformatf("rep_up_lvl@%0d", k), up_lvl, (k >= 6 && k < 39) ? 1 : 0);
      if (aumf) pulses++;
      if (k == 33) btn_up = 1'b0;
    end
    chk("rep_pulse_count", pulses, 9);

    // Bounce: no run of equal raw samples reaches four cycles.
    bval = 1'b1;
    for (int i = 0; i < 10; i++) begin
      btn_dn = bval;
      for (int j = 0; j < bounce_len[i]; j++) begin
        tick();
        chk($sformatf("bnc_dn_lvl@%0d.%0d", i, j), dn_lvl, 0);
        chk($sformatf("bnc_bajaf@%0d.%0d", i, j), bajaf, 0);
      end
      bval = ~bval;
    end
    btn_dn = 1'b0;
    for (int k = 0; k < 10; k++) begin
      tick();
      chk($sformatf("bnc_tail_dn_lvl@%0d", k), dn_lvl, 0);
      chk($sformatf("bnc_tail_bajaf@%0d", k), bajaf, 0);
    end

    // Simultaneous press. The down button is released after edge 30 and its
    // level falls at edge 36. The first unmasked up terminal count is at 38.
    tick();
    btn_up = 1'b1;
    btn_dn = 1'b1;
    for (int k = 1; k <= 50; k++) begin
      tick();
      chk($sformatf("sim_aumf@%0d", k), aumf, (k >= 38 && (k - 38) % 3 == 0) ? 1 : 0);
      chk($sformatf("sim_bajaf@%0d", k), bajaf, 0);
      chk($sformatf("sim_dn_lvl@%0d", k), dn_lvl, (k >= 6 && k < 36) ? 1 : 0);
      if (k == 30) btn_dn = 1'b0;
    end
    btn_up = 1'b0;
    repeat (20) tick();
    chk("sim_idle_up_lvl", up_lvl, 0);

    // Reset in the middle of a repeat pulse, then release it while the button is held.
    tick();
    btn_up = 1'b1;
    repeat (20) tick();
    chk("mid_aumf_before_rst", aumf, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_aumf",   aumf,   0);
    chk("mid_rst_up_lvl", up_lvl, 0);
    chk("mid_rst_bajaf",  bajaf,  0);
    chk("mid_rst_dn_lvl", dn_lvl, 0);
    tick();
    chk("mid_rst_hold_aumf", aumf, 0);
    #2 rst_n = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      tick();
      chk($sformatf("rel_aumf@%0d", k), aumf, (k == 7) ? 1 : 0);
      chk($sformatf("rel_up_lvl@%0d", k), up_lvl, (k >= 6) ? 1 : 0);
    end
    btn_up = 1'b0;
    repeat (10) tick();

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscmp_cnt);
    $finish;
  end

endmodule
